// File: rtl/eflash_pim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : eflash_pim_sequencer
//  Purpose  : PIM command sequencer for the eFlash column driver. Accepts one
//             command at a time, drives enable/mode/phase count/address into
//             the driver, and owns the 256 x 2-bit input buffer.
//  Revision : 1.0  initial release
// ============================================================================
module eflash_pim_sequencer #(
  parameter int unsigned ERASE_CYCLES = 15,
  parameter int unsigned PROG_CYCLES  = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_mode_i,
  input  logic [6:0]  cmd_row_i,
  input  logic [8:0]  cmd_col_i,
  input  logic        abort_i,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [31:0] ld_data_i,
  input  logic        ld_clear_i,
  output logic        pim_en_o,
  output logic [2:0]  pim_mode_o,
  output logic [3:0]  exec_cnt_o,
  output logic [6:0]  row_addr7_o,
  output logic [8:0]  col_addr9_o,
  output logic [1:0]  input_data_o [0:255],
  output logic        done_o,
  output logic        err_o
);

  localparam logic [3:0] c_ERASE_START = ERASE_CYCLES[3:0];
  localparam logic [3:0] c_PROG_START  = PROG_CYCLES[3:0];

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_pim_en;
  logic [2:0]  r_mode;
  logic [3:0]  r_cnt;
  logic [6:0]  r_row;
  logic [8:0]  r_col;
  logic        r_done;
  logic        r_err;
  logic [3:0]  r_wp;
  logic [1:0]  r_buf [0:255];

  logic        w_idle;
  logic        w_accept;
  logic        w_legal;
  logic [3:0]  w_start;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = cmd_valid_i & w_idle;
  assign w_legal  = (cmd_mode_i != 3'b000) && (cmd_mode_i != 3'b111);

  // Phase-count start value per command mode
  always_comb begin
    w_start = 4'd0;
    case (cmd_mode_i)
      3'b001:  w_start = c_ERASE_START;
      3'b010:  w_start = c_PROG_START;
      3'b011:  w_start = 4'd8;
      3'b100:  w_start = 4'd8;
      3'b101:  w_start = 4'd11;
      3'b110:  w_start = 4'd8;
      default: w_start = 4'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state: illegal modes are consumed without leaving IDLE; abort beats completion
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_legal) w_next_state = S_RUN;
      S_RUN:  if (abort_i || (r_cnt == 4'd0)) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Driver-facing command outputs and completion/error pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pim_en <= 1'b0;
      r_mode   <= 3'b000;
      r_cnt    <= 4'd0;
      r_row    <= 7'd0;
      r_col    <= 9'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_idle) begin
        if (w_accept) begin
          if (w_legal) begin
            r_mode   <= cmd_mode_i;
            r_row    <= cmd_row_i;
            r_col    <= cmd_col_i;
            r_cnt    <= w_start;
            r_pim_en <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end
      end else begin
        if (abort_i) begin
          r_pim_en <= 1'b0;
          r_cnt    <= 4'd0;
        end else if (r_cnt == 4'd0) begin
          r_pim_en <= 1'b0;
          r_done   <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  // Input buffer: clear has priority over a load; both frozen while a command runs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wp <= 4'd0;
      for (int i = 0; i < 256; i++) r_buf[i] <= 2'b00;
    end else if (w_idle) begin
      if (ld_clear_i) begin
        r_wp <= 4'd0;
        for (int i = 0; i < 256; i++) r_buf[i] <= 2'b00;
      end else if (ld_valid_i) begin
        for (int k = 0; k < 16; k++) r_buf[{r_wp, 4'(k)}] <= ld_data_i[2*k +: 2];
        r_wp <= r_wp + 4'd1;
      end
    end
  end

  assign cmd_ready_o  = w_idle;
  assign ld_ready_o   = w_idle;
  assign pim_en_o     = r_pim_en;
  assign pim_mode_o   = r_mode;
  assign exec_cnt_o   = r_cnt;
  assign row_addr7_o  = r_row;
  assign col_addr9_o  = r_col;
  assign input_data_o = r_buf;
  assign done_o       = r_done;
  assign err_o        = r_err;

endmodule
`default_nettype wire

// File: doc/eflash_pim_sequencer.md
# eflash_pim_sequencer

Command sequencer for the eFlash column driver. Accepts one PIM command at a time over a valid/ready handshake, then drives `pim_en`, `pim_mode`, `exec_cnt` and the row/column address into the column driver. It generates the down-counting phase count that the driver decodes. It also owns the 256 x 2-bit input buffer and loads it over a 32-bit word port; the buffer feeds the driver's `input_data_i` in parallel and row-by-row modes.

## Interface
- `ERASE_CYCLES`, default 15: start count for ERASE; legal range 1..15.
- `PROG_CYCLES`, default 15: start count for PROGRAM; legal range 1..15.
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, asynchronous and active-high.
- `cmd_valid_i`, in, 1: command valid.
- `cmd_ready_o`, out, 1: sequencer is idle and can accept a command.
- `cmd_mode_i`, in, 3: PIM mode. 001 ERASE, 010 PROGRAM, 011 READ, 100 ZP, 101 PARALLEL, 110 RBR.
- `cmd_row_i`, in, 7: row address.
- `cmd_col_i`, in, 9: column address.
- `abort_i`, in, 1: abort the running command.
- `ld_valid_i`, in, 1: load word valid.
- `ld_ready_o`, out, 1: buffer is writable.
- `ld_data_i`, in, 32: sixteen 2-bit input entries.
- `ld_clear_i`, in, 1: zero the buffer and the write pointer.
- `pim_en_o`, out, 1: to the column driver.
- `pim_mode_o`, out, 3: to the column driver.
- `exec_cnt_o`, out, 4: to the column driver.
- `row_addr7_o`, out, 7: latched row address.
- `col_addr9_o`, out, 9: latched column address.
- `input_data_o`, out, 2 x [0:255]: buffer contents.
- `done_o`, out, 1: one-cycle pulse on normal completion.
- `err_o`, out, 1: one-cycle pulse on an illegal mode.

## Operation
- **States:** two states, IDLE and RUN.
- **Status outputs:**
  - `cmd_ready_o` = (state == IDLE).
  - `ld_ready_o` = (state == IDLE). The buffer is frozen while RUN.
- **Accepting a command:** in IDLE, `cmd_valid_i & cmd_ready_o` accepts. The sequencer latches mode, row and column into `pim_mode_o`, `row_addr7_o` and `col_addr9_o`, loads `exec_cnt_o` with START(mode), sets `pim_en_o` = 1, and goes to RUN.
- **START(mode):**
  - ERASE: `ERASE_CYCLES`.
  - PROGRAM: `PROG_CYCLES`.
  - READ: 8.
  - ZP: 8.
  - PARALLEL: 11.
  - RBR: 8.
- **Illegal mode (000 or 111):** the command is consumed, the state stays IDLE, and `err_o` pulses the next cycle. `pim_en_o`, the count and the latched fields are unchanged.
- **RUN:**
  - `exec_cnt_o` decrements by 1 each cycle.
  - On the cycle where `exec_cnt_o` == 0, the next edge returns to IDLE with `pim_en_o` = 0 and `exec_cnt_o` = 0, and `done_o` pulses in that first IDLE cycle.
  - The count never wraps below 0.
- **Abort:** `abort_i` high in RUN forces IDLE at the next edge with `pim_en_o` = 0 and `exec_cnt_o` = 0. No `done_o` is issued. `abort_i` is ignored in IDLE.
  - If `abort_i` arrives on the `exec_cnt_o` == 0 cycle, abort wins and no `done_o` is issued.
- **Held outputs:** `pim_mode_o`, `row_addr7_o` and `col_addr9_o` hold their last latched values until the next accepted legal command.
- **Buffer load:**
  - A 4-bit write pointer `wp` selects the word.
  - An accepted load writes `input_data_o[16*wp + k]` = `ld_data_i[2k+1:2k]` for k = 0..15, then increments `wp`.
  - `wp` wraps from 15 to 0, overwriting from entry 0.
  - Sixteen words fill the buffer. RBR uses entries 0..31, i.e. the first two words.
- **Buffer clear:** `ld_clear_i` in IDLE zeroes all 256 entries and `wp` in one cycle.
  - `ld_clear_i` together with `ld_valid_i`: clear wins and the word is dropped.
  - `ld_clear_i` during RUN is ignored.
- **Load during RUN:** `ld_valid_i` is ignored and nothing is written.
- **Back-to-back commands:** a command may be accepted in the same cycle `done_o` is high.

## Timing
- **Reset values:**
  - `pim_en_o` 0, `pim_mode_o` 000, `exec_cnt_o` 0.
  - `row_addr7_o` 0, `col_addr9_o` 0.
  - All `input_data_o` entries 00, `wp` 0.
  - `done_o` 0, `err_o` 0.
  - State IDLE, so `cmd_ready_o` = `ld_ready_o` = 1 once `rst_i` deasserts.
- **Reset mid-RUN:** asserting `rst_i` immediately returns every output to its reset value. No `done_o` is issued.
- **Latency:** for a command accepted at edge k:
  - `pim_en_o` is high for cycles k+1 .. k+1+START, which is START+1 cycles.
  - `exec_cnt_o` takes the values START, START-1, ..., 0.
  - `done_o` is high in cycle k+2+START.
- **Registered outputs:** all driver-facing outputs are registered. The column driver adds one further register stage of its own.
- **Buffer writes:** a load accepted at edge k is visible on `input_data_o` from cycle k+1.

## Test plan
- **PARALLEL:** reset, then a PARALLEL command with row 0x25 and col 0x1A3 → `pim_en_o` high for 12 cycles, `exec_cnt_o` 11 down to 0, row/col outputs 0x25/0x1A3, `done_o` one cycle later, `cmd_ready_o` 0 throughout RUN.
- **Buffer load:** load 16 words of 0xE4E4E4E4, then a 17th word of 0xFFFFFFFF → every entry follows the 00, 01, 10, 11 pattern except entries 0..15, which read 11 after the 17th word (wrap). Then assert `ld_clear_i` together with `ld_valid_i` → all entries 00, `wp` 0.
- **Illegal mode:** command with mode 000, then mode 111 → each is accepted for one cycle, `err_o` pulses, `pim_en_o` stays 0, `pim_mode_o` keeps its prior value.
- **Abort:** READ command, `abort_i` when `exec_cnt_o` = 5 → next cycle `pim_en_o` 0, `exec_cnt_o` 0, no `done_o`. Repeat with `abort_i` on the `exec_cnt_o` = 0 cycle → no `done_o`.
- **Frozen buffer:** `ld_valid_i` and `ld_clear_i` asserted during an RBR run → buffer and `wp` unchanged, `ld_ready_o` 0. A back-to-back ERASE with `ERASE_CYCLES` = 3, offered in the `done_o` cycle → accepted in that cycle, `exec_cnt_o` runs 3, 2, 1, 0.
- **Reset mid-run:** assert `rst_i` during PROGRAM with `exec_cnt_o` = 7 → all outputs return to reset values asynchronously, no `done_o` after release.
